// File: rtl/alu_pkg.sv
// Shared types for the nibble-serial adder: per-nibble control word, FSM
// states and the result-merging helper used by loop_over_all_nibbles.
package alu_pkg;

    localparam int unsigned NIBBLES = 8;

    typedef struct packed {
        logic       carry_in;
        logic [2:0] nibble_idx;
    } AluCtrl;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } loop_state_t;

    // Drop the current nibble's sum into place; on finish the nibbles above
    // it are copied from word1 since nothing more needs adding there.
    function automatic logic [31:0] merge_nibbles(
        input logic [31:0] base,
        input logic [31:0] upper_src,
        input logic [3:0]  sum,
        input logic [2:0]  idx,
        input logic        take_upper
    );
        logic [31:0] r;
        r = base;
        for (int unsigned n = 0; n < NIBBLES; n++) begin
            if (n == 32'(idx)) begin
                r[n*4 +: 4] = sum;
            end else if (take_upper && (n > 32'(idx))) begin
                r[n*4 +: 4] = upper_src[n*4 +: 4];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/loop_over_all_nibbles_if.sv
// Operand/result bundle between the core control FSM (master) and the
// nibble-serial adder (slave).
interface loop_over_all_nibbles_if;
    import alu_pkg::*;

    logic        loop_perm_to_count;
    logic [2:0]  loop_nibbles_number;
    logic        word2_is_negative;
    logic [31:0] word1;
    logic [31:0] word2;
    logic [31:0] preinit_result;
    AluCtrl      ctrl;
    logic [31:0] result;
    logic        busy;

    modport master (
        output loop_perm_to_count, loop_nibbles_number, word2_is_negative,
               word1, word2, preinit_result,
        input  ctrl, result, busy
    );

    modport slave (
        input  loop_perm_to_count, loop_nibbles_number, word2_is_negative,
               word1, word2, preinit_result,
        output ctrl, result, busy
    );

endinterface

// File: rtl/alu_nibble.sv
// 4-bit adder slice, time-multiplexed across the eight nibbles of a word.
module alu_nibble (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       carry_in,
    output logic [3:0] sum,
    output logic       carry_out
);

    assign {carry_out, sum} = 5'(a) + 5'(b) + 5'(carry_in);

endmodule

// File: rtl/loop_over_all_nibbles.sv
// Nibble-serial 32-bit adder, LSB nibble first, stalling the control FSM via busy.
// Define LOOP_NIBBLES_EARLY_EXIT_EN to finish as soon as the upper nibbles equal word1.
module loop_over_all_nibbles
    import alu_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    loop_over_all_nibbles_if.slave   bus
);

    loop_state_t state;
    logic [2:0]  idx;
    logic        carry;
    logic [31:0] result_reg;

    logic [3:0]  op_a;
    logic [3:0]  op_b;
    logic [3:0]  sum;
    logic        carry_out;
    logic        active;
    logic        last_nibble;
    logic        early_exit;
    logic        finish;
    logic [31:0] merged;

    always_comb begin
        op_a = bus.word1[{idx, 2'b00} +: 4];
        op_b = {4{bus.word2_is_negative}};
        if (idx <= bus.loop_nibbles_number) begin
            op_b = bus.word2[{idx, 2'b00} +: 4];
        end
    end

    alu_nibble u_nibble (
        .a         (op_a),
        .b         (op_b),
        .carry_in  (carry),
        .sum       (sum),
        .carry_out (carry_out)
    );

    // rst_n gates the combinational outputs so busy/result read 0 during reset.
    assign active      = rst_n && bus.loop_perm_to_count && (state != ST_DONE);
    assign last_nibble = (idx == 3'(NIBBLES - 1));

`ifdef LOOP_NIBBLES_EARLY_EXIT_EN
    assign early_exit = (idx >= bus.loop_nibbles_number) && !carry_out
                        && !bus.word2_is_negative;
`else
    assign early_exit = 1'b0;
`endif

    assign finish = active && (last_nibble || early_exit);
    assign merged = active ? merge_nibbles(result_reg, bus.word1, sum, idx, finish)
                           : result_reg;

    assign bus.busy               = active && !finish;
    assign bus.result             = merged;
    assign bus.ctrl.carry_in      = carry;
    assign bus.ctrl.nibble_idx    = idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            idx        <= '0;
            carry      <= 1'b0;
            result_reg <= '0;
        end else if (!bus.loop_perm_to_count) begin
            state      <= ST_IDLE;
            idx        <= '0;
            carry      <= 1'b0;
            result_reg <= bus.preinit_result;
        end else if (state != ST_DONE) begin
            result_reg <= merged;
            if (finish) begin
                state <= ST_DONE;
                idx   <= '0;
                carry <= 1'b0;
            end else begin
                state <= ST_RUN;
                idx   <= idx + 3'd1;
                carry <= carry_out;
            end
        end
    end

endmodule

// File: tb/tb_loop_over_all_nibbles.sv
// Self-checking bench for loop_over_all_nibbles: directed vectors with literal
// expectations plus a per-cycle arithmetic model of busy/ctrl/result.
module tb_loop_over_all_nibbles;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    loop_over_all_nibbles_if bus ();

    loop_over_all_nibbles dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    function automatic logic [31:0] ext_w2(input logic [31:0] w2, input logic [2:0] n,
                                           input logic neg);
        longint unsigned lo;
        int unsigned nn;
        nn = n;
        lo = (64'd1 << (4 * (nn + 1))) - 64'd1;
        return (w2 & lo[31:0]) | (neg ? ~lo[31:0] : 32'h0);
    endfunction

    // Carry entering nibble j of w1 + w2e.
    function automatic logic carry_into(input logic [31:0] w1, input logic [31:0] w2e,
                                        input int unsigned j);
        longint unsigned m;
        longint unsigned s;
        m = (64'd1 << (4 * j)) - 64'd1;
        s = ({32'h0, w1} & m) + ({32'h0, w2e} & m);
        return ((s >> (4 * j)) & 64'd1) != 0;
    endfunction

    function automatic int unsigned finish_idx(input logic [31:0] w1, input logic [31:0] w2,
                                               input logic [2:0] n, input logic neg);
        int unsigned k;
        k = 7;
`ifdef LOOP_NIBBLES_EARLY_EXIT_EN
        for (int unsigned i = n; i < 7; i++) begin
            if (!neg && !carry_into(w1, ext_w2(w2, n, neg), i + 1)) begin
                k = i;
                break;
            end
        end
`endif
        return k;
    endfunction

    // ---------------- per-cycle compare ----------------
    int unsigned j_cyc = 0;
    logic        prev_idle = 1'b0;
    logic [31:0] prev_pre = '0;

    always @(negedge clk) begin
        logic [31:0] w2e;
        logic [31:0] exp_sum;
        int unsigned k;
        if (!rst_n) begin
            check("rst_busy", 32'(bus.busy), 32'h0);
            check("rst_ctrl", 32'(bus.ctrl), 32'h0);
            check("rst_result", bus.result, 32'h0);
            j_cyc = 0;
        end else if (!bus.loop_perm_to_count) begin
            check("idle_busy", 32'(bus.busy), 32'h0);
            if (prev_idle) begin
                check("idle_ctrl", 32'(bus.ctrl), 32'h0);
                check("idle_result", bus.result, prev_pre);
            end
            j_cyc = 0;
        end else begin
            w2e     = ext_w2(bus.word2, bus.loop_nibbles_number, bus.word2_is_negative);
            exp_sum = bus.word1 + w2e;
            k       = finish_idx(bus.word1, bus.word2, bus.loop_nibbles_number,
                                 bus.word2_is_negative);
            if (j_cyc <= k) begin
                check("run_ctrl", 32'(bus.ctrl),
                      {28'h0, carry_into(bus.word1, w2e, j_cyc), j_cyc[2:0]});
            end
            if (j_cyc < k) begin
                check("run_busy", 32'(bus.busy), 32'h1);
            end else begin
                check("fin_busy", 32'(bus.busy), 32'h0);
                check("fin_result", bus.result, exp_sum);
            end
            j_cyc++;
        end
        prev_idle = rst_n && !bus.loop_perm_to_count;
        prev_pre  = bus.preinit_result;
    end

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [2:0]  n;
        logic        neg;
        logic [31:0] w1;
        logic [31:0] w2;
        logic [31:0] pre;
        logic [31:0] res;
        int          cyc_early;
    } vec_t;

    vec_t vecs[8];

    task automatic run_vec(input vec_t v);
        int cnt;
        int exp_cyc;
`ifdef LOOP_NIBBLES_EARLY_EXIT_EN
        exp_cyc = v.cyc_early;
`else
        exp_cyc = 8;
`endif
        @(posedge clk); #1;
        bus.loop_nibbles_number = v.n;
        bus.word2_is_negative   = v.neg;
        bus.word1               = v.w1;
        bus.word2               = v.w2;
        bus.preinit_result      = v.pre;
        bus.loop_perm_to_count  = 1'b1;
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (bus.busy && cnt < 20);
        check("vec_cycles", 32'(cnt), 32'(exp_cyc));
        check("vec_result", bus.result, v.res);
        @(negedge clk);
        check("done_busy", 32'(bus.busy), 32'h0);
        check("done_result", bus.result, v.res);
        @(posedge clk); #1;
        bus.loop_perm_to_count = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        vecs[0] = '{3'd0, 1'b0, 32'h000000FF, 32'h00000004, 32'h000000FF, 32'h00000103, 3};
        vecs[1] = '{3'd2, 1'b0, 32'h0000007B, 32'h00000002, 32'h0, 32'h0000007D, 3};
        vecs[2] = '{3'd2, 1'b0, 32'h0000007B, 32'h00000005, 32'h0, 32'h00000080, 3};
        vecs[3] = '{3'd2, 1'b1, 32'h00000000, 32'h00000800, 32'h0, 32'hFFFFF800, 8};
        vecs[4] = '{3'd2, 1'b1, 32'h0000007B, 32'h00000FFE, 32'h0, 32'h00000079, 8};
        vecs[5] = '{3'd0, 1'b0, 32'h00000005, 32'h00000001, 32'hDEADBEEF, 32'h00000006, 1};
        vecs[6] = '{3'd7, 1'b0, 32'h12345678, 32'h11111111, 32'h0, 32'h23456789, 8};
        vecs[7] = '{3'd1, 1'b0, 32'hFFFFFFF0, 32'h00000010, 32'h0, 32'h00000000, 8};

        rst_n                   = 1'b1;
        bus.loop_perm_to_count  = 1'b0;
        bus.loop_nibbles_number = 3'd0;
        bus.word2_is_negative   = 1'b0;
        bus.word1               = '0;
        bus.word2               = '0;
        bus.preinit_result      = 32'hA5A5A5A5;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("preinit_after_reset", bus.result, 32'hA5A5A5A5);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset pulled in the middle of an addition.
        @(posedge clk); #1;
        bus.loop_nibbles_number = 3'd7;
        bus.word2_is_negative   = 1'b0;
        bus.word1               = 32'hFFFFFFFF;
        bus.word2               = 32'h00000001;
        bus.loop_perm_to_count  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("mid_ctrl", 32'(bus.ctrl), 32'hB);
        check("mid_busy", 32'(bus.busy), 32'h1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(bus.busy), 32'h0);
        check("abort_result", bus.result, 32'h0);
        check("abort_ctrl", 32'(bus.ctrl), 32'h0);
        @(posedge clk); #1;
        bus.loop_perm_to_count = 1'b0;
        @(posedge clk); #1;
        rst_n              = 1'b1;
        bus.preinit_result = 32'h13572468;
        @(posedge clk); #1;
        check("preinit_track", bus.result, 32'h13572468);
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
